// File: rtl/max_pool_2x2_pkg.sv
// Shared types and defaults for the 2x2 max-pooling block.
package max_pool_2x2_pkg;

    localparam int unsigned DATA_W_DEF = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Input/output stream handshake bundle for max_pool_2x2.
interface max_pool_2x2_if
    import max_pool_2x2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    // Pooling block side: consumes the conv stream, produces pooled values.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Environment side: produces conv results, consumes pooled values.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/max_pool_2x2_signed_max2.sv
// Two-input signed maximum; ties return the shared value.
module signed_max2
    import max_pool_2x2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    always_comb begin
        y = (a >= b) ? a : b;
    end

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max pooling over a ROWS x COLS signed feature map (row-major).
// Optional zero_count output is enabled by defining MAX_POOL_ZERO_CNT_EN.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned COLS   = 4,
    parameter int unsigned ROWS   = 4,
    localparam int unsigned ZCW   = $clog2(ROWS * COLS / 4) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    max_pool_2x2_if.slave    bus,
    output logic             busy,
    output logic             frame_done
`ifdef MAX_POOL_ZERO_CNT_EN
    ,
    output logic [ZCW-1:0]   zero_count
`endif
);

    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LBD = COLS / 2;
    localparam int unsigned LBW = (LBD > 1) ? $clog2(LBD) : 1;

    state_t state, state_nxt;

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] h_reg;
    logic signed [DATA_W-1:0] lb [LBD];
    logic [LBW-1:0]           lb_idx;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] pool_max;
    logic                     ov;
    logic signed [DATA_W-1:0] od;

    logic accept, xfer, load, col_last, row_last, start_go;

    assign bus.in_ready  = (state == RUN) && (!ov || bus.out_ready);
    assign bus.out_valid = ov;
    assign bus.out_data  = od;

    assign accept   = bus.in_valid && bus.in_ready;
    assign xfer     = ov && bus.out_ready;
    assign col_last = (col == CW'(COLS - 1));
    assign row_last = (row == RW'(ROWS - 1));
    assign lb_idx   = LBW'(col >> 1);
    assign load     = accept && col[0] && row[0];
    assign busy     = (state != IDLE);

    signed_max2 #(.DATA_W(DATA_W)) u_pair_max (
        .a (h_reg),
        .b (bus.in_data),
        .y (pair_max)
    );

    signed_max2 #(.DATA_W(DATA_W)) u_pool_max (
        .a (lb[lb_idx]),
        .b (pair_max),
        .y (pool_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE waits for the last pooled value to leave before returning to IDLE.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        start_go   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_go  = 1'b1;
                end
            end
            RUN: begin
                if (accept && col_last && row_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!ov || bus.out_ready) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            h_reg <= '0;
            for (int unsigned i = 0; i < LBD; i++) begin
                lb[i] <= '0;
            end
        end else if (start_go) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (!col[0]) begin
                h_reg <= bus.in_data;
            end else if (!row[0]) begin
                lb[lb_idx] <= pair_max;
            end
        end
    end

    // A load in the same cycle as a transfer keeps out_valid high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov <= 1'b0;
            od <= '0;
        end else if (start_go) begin
            ov <= 1'b0;
        end else if (load) begin
            ov <= 1'b1;
            od <= pool_max;
        end else if (xfer) begin
            ov <= 1'b0;
        end
    end

`ifdef MAX_POOL_ZERO_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_count <= '0;
        end else if (start_go) begin
            zero_count <= '0;
        end else if (xfer && (od == '0)) begin
            zero_count <= zero_count + ZCW'(1);
        end
    end
`endif

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameter DATA_W, default 22, width of the signed conv/ReLU result stream.
REQ-002 Parameter COLS, default 4, feature-map columns; SHALL be even and at least 2.
REQ-003 Parameter ROWS, default 4, feature-map rows; SHALL be even and at least 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a new frame.
REQ-007 in_valid  input  1  in_data carries a conv result.
REQ-008 in_data  input  DATA_W signed  conv result, row-major order.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a pooled value.
REQ-011 out_data  output  DATA_W signed  2x2 maximum.
REQ-012 out_ready  input  1  consumer takes out_data this cycle.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 An input is accepted exactly when in_valid and in_ready are both high; an output transfers exactly when out_valid and out_ready are both high.
REQ-016 FSM states are IDLE, RUN and DONE.
- IDLE goes to RUN on start, clearing the column, row and output state.
- RUN goes to DONE on acceptance of pixel (ROWS-1, COLS-1).
- DONE goes to IDLE once out_valid is low or transfers; frame_done pulses on that cycle.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 in_ready = (state==RUN) && (!out_valid || out_ready); it is combinational and low in IDLE and DONE.
REQ-019 Column and row counters advance per accepted pixel only; the column wraps at COLS-1 and increments the row.
REQ-020 Even column: hold h_reg = in_data. Odd column: pair max = max(h_reg, in_data), signed compare.
REQ-021 Even row, odd column: write the pair max to line buffer entry [col/2], depth COLS/2.
REQ-022 Odd row, odd column: load out_data = max(line buffer[col/2], pair max) and set out_valid on the next edge; latency is 1 cycle from the completing accept.
REQ-023 An output transfer and a new output load in the same cycle SHALL keep out_valid high with the new value; a transfer alone clears out_valid.
REQ-024 Ties return the equal value; no arithmetic widening; out_data width equals DATA_W.
REQ-025 out_data SHALL hold its value while out_valid is high and out_ready is low.
REQ-026 Each frame produces exactly (ROWS/2)*(COLS/2) outputs, in row-major pooled order.

Reset
REQ-027 rst_n low SHALL asynchronously force:
- state IDLE and counters 0;
- h_reg and line buffer 0;
- out_valid 0, out_data 0, frame_done 0, busy 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; no frame_done is emitted for it.

Configuration
REQ-029 Macro MAX_POOL_ZERO_CNT_EN, when defined, adds output zero_count (width $clog2(ROWS*COLS/4)+1).
- zero_count counts transferred outputs equal to 0 and clears on start.
- When the macro is undefined, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-030 A shared package holds the FSM state typedef (IDLE/RUN/DONE) and the default DATA_W=22.
REQ-031 One sub-module, signed_max2, performs the DATA_W signed two-input maximum; it is instantiated twice.

Verification
REQ-032 4x4 frame of values 0..15 row-major, out_ready=1 -> outputs 5, 7, 13, 15, then frame_done one cycle after the accept of 15 drains.
REQ-033 Negative values: window {-3,-1,-8,-2} -> out_data=-1, confirming signed compare.
REQ-034 out_ready=0 while the first pooled value is pending -> in_ready low, out_data held; release out_ready -> streaming resumes with no loss.
REQ-035 rst_n low after 6 accepted pixels, then start plus a full frame -> only the new frame's 4 outputs, correct values.
REQ-036 start pulsed during RUN -> ignored, output sequence unchanged.
REQ-037 With MAX_POOL_ZERO_CNT_EN, a frame of all zeros -> zero_count=4; a next frame of 0..15 -> zero_count=0.
